// File: rtl/pucch_bit_mapper.sv
// PUCCH UCI bit mapper: pops packed UCI words from the bit FIFO and serialises them LSB-first
// into BPSK/QPSK constellation points on a valid/ready symbol stream.
module pucch_bit_mapper #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BITS   = 64,
  parameter int SYM_WIDTH  = 16,
  parameter int AMP        = 23170
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic [$clog2(MAX_BITS+1)-1:0]     i_num_bits,
  input  logic                              i_qpsk,
  input  logic                              i_fifo_empty,
  input  logic [DATA_WIDTH-1:0]             i_fifo_data,
  output logic                              o_fifo_pop,
  output logic signed [SYM_WIDTH-1:0]       o_sym_i,
  output logic signed [SYM_WIDTH-1:0]       o_sym_q,
  output logic                              o_sym_valid,
  input  logic                              i_sym_ready,
  output logic                              o_sym_last,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam int NbW = $clog2(MAX_BITS + 1);
  localparam int WbW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPop  = 3'd1;
  localparam logic [2:0] StLoad = 3'd2;
  localparam logic [2:0] StEmit = 3'd3;
  localparam logic [2:0] StFin  = 3'd4;

  localparam logic signed [SYM_WIDTH-1:0] PosAmp = SYM_WIDTH'(AMP);
  localparam logic signed [SYM_WIDTH-1:0] NegAmp = SYM_WIDTH'(-AMP);

  logic [2:0]            r_state;
  logic [2:0]            w_state_next;
  logic [NbW-1:0]        r_bits_left;
  logic [WbW-1:0]        r_word_bits;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_qpsk;

  logic [NbW-1:0]        w_num_sat;
  logic [NbW-1:0]        w_step_b;
  logic [WbW-1:0]        w_step_w;
  logic                  w_hs;
  logic                  w_frame_end;
  logic                  w_word_end;
  logic                  w_b0;
  logic                  w_b1;
  logic                  w_qbit;

  assign w_num_sat   = (i_num_bits > NbW'(MAX_BITS)) ? NbW'(MAX_BITS) : i_num_bits;
  assign w_step_b    = r_qpsk ? NbW'(2) : NbW'(1);
  assign w_step_w    = r_qpsk ? WbW'(2) : WbW'(1);
  assign w_hs        = o_sym_valid && i_sym_ready;
  assign w_frame_end = (r_bits_left <= w_step_b);
  assign w_word_end  = (r_word_bits <= w_step_w);

  // With a single bit left in QPSK the second bit is padding and reads as 0.
  assign w_b0   = r_shift[0];
  assign w_b1   = r_shift[1] && (r_bits_left >= NbW'(2));
  assign w_qbit = r_qpsk ? w_b1 : w_b0;

  assign o_fifo_pop  = (r_state == StPop) && !i_fifo_empty;
  assign o_sym_valid = (r_state == StEmit);
  assign o_sym_last  = o_sym_valid && w_frame_end;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = (r_state == StFin);
  assign o_sym_i     = !o_sym_valid ? '0 : (w_b0 ? NegAmp : PosAmp);
  assign o_sym_q     = !o_sym_valid ? '0 : (w_qbit ? NegAmp : PosAmp);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = (i_num_bits == '0) ? StFin : StPop;
        end
      end
      StPop: begin
        if (!i_fifo_empty) begin
          w_state_next = StLoad;
        end
      end
      StLoad: w_state_next = StEmit;
      StEmit: begin
        if (w_hs) begin
          if (w_frame_end) begin
            w_state_next = StFin;
          end else if (w_word_end) begin
            w_state_next = StPop;
          end
        end
      end
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_bits_left <= '0;
      r_word_bits <= '0;
      r_shift     <= '0;
      r_qpsk      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (i_start && (i_num_bits != '0)) begin
            r_bits_left <= w_num_sat;
            r_qpsk      <= i_qpsk;
          end
        end
        StLoad: begin
          r_shift     <= i_fifo_data;
          r_word_bits <= WbW'(DATA_WIDTH);
        end
        StEmit: begin
          if (w_hs) begin
            r_shift     <= r_qpsk ? (r_shift >> 2) : (r_shift >> 1);
            r_word_bits <= w_word_end ? '0 : (r_word_bits - w_step_w);
            r_bits_left <= w_frame_end ? '0 : (r_bits_left - w_step_b);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pucch_bit_mapper.sv
// Scoreboard bench for pucch_bit_mapper: directed frames, a FIFO model and a symbol monitor.
module tb_pucch_bit_mapper;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic               last;
  } sym_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_start = 1'b0;
  logic [6:0]         i_num_bits = '0;
  logic               i_qpsk = 1'b0;
  logic               i_fifo_empty;
  logic [7:0]         i_fifo_data = '0;
  logic               o_fifo_pop;
  logic signed [15:0] o_sym_i;
  logic signed [15:0] o_sym_q;
  logic               o_sym_valid;
  logic               i_sym_ready = 1'b1;
  logic               o_sym_last;
  logic               o_busy;
  logic               o_done;

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   pops = 0;
  int   pop_cyc = -1;
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic [7:0] mem [0:31];
  sym_t exp_q [$];
  int   hs_cyc [$];

  assign i_fifo_empty = (wr_ptr == rd_ptr);

  pucch_bit_mapper #(
    .DATA_WIDTH(8),
    .MAX_BITS  (64),
    .SYM_WIDTH (16),
    .AMP       (23170)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_num_bits  (i_num_bits),
    .i_qpsk      (i_qpsk),
    .i_fifo_empty(i_fifo_empty),
    .i_fifo_data (i_fifo_data),
    .o_fifo_pop  (o_fifo_pop),
    .o_sym_i     (o_sym_i),
    .o_sym_q     (o_sym_q),
    .o_sym_valid (o_sym_valid),
    .i_sym_ready (i_sym_ready),
    .o_sym_last  (o_sym_last),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint expv);
    nvec++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic expect_sym(input bit ineg, input bit qneg, input bit last);
    sym_t s;
    s.i    = ineg ? -16'sd23170 : 16'sd23170;
    s.q    = qneg ? -16'sd23170 : 16'sd23170;
    s.last = last;
    exp_q.push_back(s);
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr % 32] = w;
    wr_ptr++;
  endtask

  function automatic int hs_at(input int k);
    return (hs_cyc.size() > k) ? hs_cyc[k] : -100;
  endfunction

  task automatic cycle_counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  // Read data appears the cycle after the accepted pop.
  task automatic fifo_proc();
    forever begin
      @(negedge clk);
      if (o_fifo_pop && !rst) begin
        pop_cyc = cyc;
        @(posedge clk);
        if (!rst) begin
          #1;
          i_fifo_data = mem[rd_ptr % 32];
          rd_ptr++;
          pops++;
        end
      end
    end
  endtask

  task automatic monitor();
    logic               held = 1'b0;
    logic signed [15:0] h_i = '0;
    logic signed [15:0] h_q = '0;
    logic               h_last = 1'b0;
    sym_t               e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("stall_valid", o_sym_valid, 1);
          chk("stall_i", o_sym_i, h_i);
          chk("stall_q", o_sym_q, h_q);
          chk("stall_last", o_sym_last, h_last);
        end
        if (o_sym_valid && i_sym_ready) begin
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_sym", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("sym_i", o_sym_i, e.i);
            chk("sym_q", o_sym_q, e.q);
            chk("sym_last", o_sym_last, e.last);
          end
        end
        held   = o_sym_valid && !i_sym_ready;
        h_i    = o_sym_i;
        h_q    = o_sym_q;
        h_last = o_sym_last;
      end
    end
  endtask

  task automatic start(input int nb, input bit q, output int s);
    @(posedge clk);
    #1;
    i_start    = 1'b1;
    i_num_bits = 7'(nb);
    i_qpsk     = q;
    s          = cyc;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int d);
    d = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (o_done) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int s;
    int d;
    int p0;
    bit seen;

    fork
      cycle_counter();
      fifo_proc();
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_sym_valid, 0);
    chk("rst_pop", o_fifo_pop, 0);
    chk("rst_done", o_done, 0);
    chk("rst_sym_i", o_sym_i, 0);
    chk("rst_sym_q", o_sym_q, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // QPSK, 8 bits from 8'b1110_0100.
    push(8'hE4);
    expect_sym(0, 0, 0);
    expect_sym(1, 0, 0);
    expect_sym(0, 1, 0);
    expect_sym(1, 1, 1);
    hs_cyc.delete();
    p0 = pops;
    start(8, 1'b1, s);
    wait_done(40, d);
    chk("qpsk_latency", hs_at(0) - s, 3);
    chk("qpsk_back2back", hs_at(3) - hs_at(0), 3);
    chk("qpsk_done_after_last", d, hs_at(3) + 1);
    chk("qpsk_pops", pops - p0, 1);
    chk("qpsk_drained", exp_q.size(), 0);

    // BPSK, 10 bits over two words: refill bubble between them.
    push(8'hFF);
    push(8'h01);
    for (int k = 0; k < 9; k++) expect_sym(1, 1, 0);
    expect_sym(0, 0, 1);
    hs_cyc.delete();
    p0 = pops;
    start(10, 1'b0, s);
    wait_done(60, d);
    chk("bpsk_refill_gap", hs_at(8) - hs_at(7), 3);
    chk("bpsk_in_word", hs_at(7) - hs_at(0), 7);
    chk("bpsk_pops", pops - p0, 2);
    chk("bpsk_drained", exp_q.size(), 0);

    // FIFO empty at start; word arrives 5 cycles later.
    expect_sym(0, 0, 0);
    expect_sym(1, 1, 1);
    hs_cyc.delete();
    p0   = pops;
    seen = 1'b0;
    start(2, 1'b0, s);
    repeat (5) begin
      @(negedge clk);
      if (o_fifo_pop) seen = 1'b1;
    end
    chk("pop_while_empty", seen, 0);
    @(posedge clk);
    #1 push(8'h02);
    wait_done(40, d);
    chk("empty_first_sym", hs_at(0) - pop_cyc, 2);
    chk("empty_pops", pops - p0, 1);
    chk("empty_drained", exp_q.size(), 0);

    // Backpressure: ready low for 4 cycles after the first handshake.
    push(8'h1B);
    expect_sym(1, 1, 0);
    expect_sym(0, 1, 0);
    expect_sym(1, 0, 0);
    expect_sym(0, 0, 1);
    hs_cyc.delete();
    start(8, 1'b1, s);
    repeat (3) @(posedge clk);
    #1 i_sym_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 i_sym_ready = 1'b1;
    wait_done(40, d);
    chk("bp_gap", hs_at(1) - hs_at(0), 5);
    chk("bp_count", hs_cyc.size(), 4);
    chk("bp_drained", exp_q.size(), 0);

    // QPSK odd length: pad bit replaces b3.
    push(8'h0F);
    expect_sym(1, 1, 0);
    expect_sym(1, 0, 1);
    hs_cyc.delete();
    p0 = pops;
    start(3, 1'b1, s);
    wait_done(40, d);
    chk("odd_count", hs_cyc.size(), 2);
    chk("odd_pops", pops - p0, 1);
    chk("odd_drained", exp_q.size(), 0);

    // Zero-length frame.
    hs_cyc.delete();
    p0 = pops;
    start(0, 1'b0, s);
    wait_done(10, d);
    chk("zero_done_timing", ((d - s) >= 1) && ((d - s) <= 2), 1);
    chk("zero_pops", pops - p0, 0);
    chk("zero_syms", hs_cyc.size(), 0);
    @(negedge clk);
    chk("zero_idle", o_busy, 0);

    // Start while busy is ignored.
    push(8'h01);
    expect_sym(1, 1, 0);
    expect_sym(0, 0, 1);
    hs_cyc.delete();
    p0 = pops;
    start(2, 1'b0, s);
    @(posedge clk);
    #1;
    i_start    = 1'b1;
    i_num_bits = 7'd8;
    i_qpsk     = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    wait_done(40, d);
    repeat (6) @(negedge clk);
    chk("busy_start_syms", hs_cyc.size(), 2);
    chk("busy_start_pops", pops - p0, 1);
    chk("busy_start_idle", o_busy, 0);

    // Reset while a symbol is held valid.
    push(8'hAA);
    i_sym_ready = 1'b0;
    start(8, 1'b0, s);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_valid", o_sym_valid, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", o_sym_valid, 0);
    chk("mid_rst_last", o_sym_last, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_sym_i", o_sym_i, 0);
    chk("mid_rst_sym_q", o_sym_q, 0);
    chk("mid_rst_done", o_done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    i_sym_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", o_busy, 0);

    push(8'hE4);
    expect_sym(0, 0, 0);
    expect_sym(1, 0, 0);
    expect_sym(0, 1, 0);
    expect_sym(1, 1, 1);
    hs_cyc.delete();
    p0 = pops;
    start(8, 1'b1, s);
    wait_done(40, d);
    chk("post_rst_latency", hs_at(0) - s, 3);
    chk("post_rst_pops", pops - p0, 1);
    chk("post_rst_drained", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
